// File: rtl/xbox_xlr_line_copy_seq_if.sv
// Accelerator-mastered XBOX memory port: one address/data/strobe lane per memory instance.
// Read data returns the cycle after the read strobe.
interface xbox_xlr_line_copy_seq_if #(
  parameter int unsigned NUM_MEMS           = 1,
  parameter int unsigned LOG2_LINES_PER_MEM = 4
);
  logic [NUM_MEMS-1:0][LOG2_LINES_PER_MEM-1:0] xlr_mem_addr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_wdata;
  logic [NUM_MEMS-1:0][31:0]                   xlr_mem_be;
  logic [NUM_MEMS-1:0]                         xlr_mem_rd;
  logic [NUM_MEMS-1:0]                         xlr_mem_wr;
  logic [NUM_MEMS-1:0][7:0][31:0]              xlr_mem_rdata;

  modport master (
    output xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    input  xlr_mem_rdata
  );

  modport slave (
    input  xlr_mem_addr, xlr_mem_wdata, xlr_mem_be, xlr_mem_rd, xlr_mem_wr,
    output xlr_mem_rdata
  );
endinterface

// File: rtl/xbox_xlr_line_copy_seq.sv
// XBOX accelerator: copies LEN 256-bit lines from SRC to DST, one read/write pair per line,
// in ascending order. Configured and observed through the host register file.
module xbox_xlr_line_copy_seq #(
  parameter int unsigned NUM_MEMS           = 1,
  parameter int unsigned LOG2_LINES_PER_MEM = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  xbox_xlr_line_copy_seq_if.master mem,
  input  logic [31:0][31:0]        host_regs,
  input  logic [31:0]              host_regs_valid_pulse,
  output logic [31:0][31:0]        host_regs_data_out,
  output logic [31:0]              host_regs_valid_out,
  input  logic [18:0]              trig_soc_xmem_wr_addr,
  input  logic                     trig_soc_xmem_wr
);

  localparam int unsigned LW          = LOG2_LINES_PER_MEM;
  localparam int unsigned TOTAL_LINES = NUM_MEMS << LOG2_LINES_PER_MEM;

  typedef enum logic [2:0] {IDLE, CHK, RD, CAP, WR, FIN} state_t;

  state_t      state_q;
  logic [15:0] src_q, dst_q, rem_q, progress_q;
  logic        busy_q, done_q, err_q;

  logic                start_c;
  logic [15:0]         rd_g_c;
  logic [NUM_MEMS-1:0] rd_sel_c, src_sel_c, dst_sel_c;
  logic [7:0][31:0]    cap_data_c;
  logic [16:0]         src_end_c, dst_end_c;
  logic                bounds_err_c;

  // One-hot instance select for a global line index.
  function automatic logic [NUM_MEMS-1:0] inst_sel(input logic [15:0] g);
    logic [15:0] inst;
    inst     = g >> LOG2_LINES_PER_MEM;
    inst_sel = '0;
    for (int i = 0; i < NUM_MEMS; i++) inst_sel[i] = (inst == 16'(i));
  endfunction

  assign start_c      = host_regs_valid_pulse[0] & host_regs[0][0];
  // The read issued from WR targets the line after the one being written.
  assign rd_g_c       = (state_q == WR) ? src_q + 16'd1 : src_q;
  assign rd_sel_c     = inst_sel(rd_g_c);
  assign src_sel_c    = inst_sel(src_q);
  assign dst_sel_c    = inst_sel(dst_q);
  assign src_end_c    = {1'b0, src_q} + {1'b0, rem_q};
  assign dst_end_c    = {1'b0, dst_q} + {1'b0, rem_q};
  assign bounds_err_c = (src_end_c > 17'(TOTAL_LINES)) || (dst_end_c > 17'(TOTAL_LINES));

  always_comb begin
    cap_data_c = '0;
    for (int i = 0; i < NUM_MEMS; i++) begin
      if (src_sel_c[i]) cap_data_c = mem.xlr_mem_rdata[i];
    end
  end

  // Sequencer; memory strobes are issued one cycle ahead so they are registered in the target state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      src_q             <= '0;
      dst_q             <= '0;
      rem_q             <= '0;
      progress_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      err_q             <= 1'b0;
      mem.xlr_mem_addr  <= '0;
      mem.xlr_mem_wdata <= '0;
      mem.xlr_mem_be    <= '0;
      mem.xlr_mem_rd    <= '0;
      mem.xlr_mem_wr    <= '0;
    end else begin
      mem.xlr_mem_addr  <= '0;
      mem.xlr_mem_wdata <= '0;
      mem.xlr_mem_be    <= '0;
      mem.xlr_mem_rd    <= '0;
      mem.xlr_mem_wr    <= '0;
      unique case (state_q)
        IDLE: begin
          if (start_c) begin
            src_q      <= host_regs[1][15:0];
            dst_q      <= host_regs[2][15:0];
            rem_q      <= host_regs[3][15:0];
            progress_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= CHK;
          end
        end
        CHK: begin
          if (bounds_err_c) begin
            err_q   <= 1'b1;
            state_q <= FIN;
          end else if (rem_q == 16'd0) begin
            state_q <= FIN;
          end else begin
            for (int i = 0; i < NUM_MEMS; i++) begin
              if (rd_sel_c[i]) begin
                mem.xlr_mem_rd[i]   <= 1'b1;
                mem.xlr_mem_addr[i] <= LW'(rd_g_c);
              end
            end
            state_q <= RD;
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          // The wdata register of the destination lane doubles as the line buffer.
          for (int i = 0; i < NUM_MEMS; i++) begin
            if (dst_sel_c[i]) begin
              mem.xlr_mem_wr[i]    <= 1'b1;
              mem.xlr_mem_be[i]    <= '1;
              mem.xlr_mem_wdata[i] <= cap_data_c;
              mem.xlr_mem_addr[i]  <= LW'(dst_q);
            end
          end
          state_q <= WR;
        end
        WR: begin
          src_q      <= src_q + 16'd1;
          dst_q      <= dst_q + 16'd1;
          progress_q <= progress_q + 16'd1;
          rem_q      <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_q <= FIN;
          end else begin
            for (int i = 0; i < NUM_MEMS; i++) begin
              if (rd_sel_c[i]) begin
                mem.xlr_mem_rd[i]   <= 1'b1;
                mem.xlr_mem_addr[i] <= LW'(rd_g_c);
              end
            end
            state_q <= RD;
          end
        end
        FIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    host_regs_data_out    = '0;
    host_regs_data_out[4] = {29'd0, err_q, done_q, busy_q};
    host_regs_data_out[5] = {16'd0, progress_q};
  end

  assign host_regs_valid_out = 32'h0000_0030;

  logic unused_inputs;
  assign unused_inputs = ^{host_regs[31:4], host_regs[3][31:16], host_regs[2][31:16],
                           host_regs[1][31:16], host_regs[0][31:1],
                           host_regs_valid_pulse[31:1], trig_soc_xmem_wr_addr, trig_soc_xmem_wr};

endmodule
